// File: rtl/aud_codec_emu.sv
// Codec-side audio serial link emulator: LRCK master, ADC serial transmitter fed from a
// small stereo-pair FIFO, and DAC serial capture, all clocked on the AUD_BCLK rising edge.
module aud_codec_emu #(
   parameter int WORD_W     = 16,
   parameter int HALF_LEN   = 32,
   parameter int DELAY      = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                AUD_BCLK,
   input  logic                NRST,
   input  logic                en,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [2*WORD_W-1:0] s_data,
   output logic                AUD_ADCLRCK,
   output logic                AUD_DACLRCK,
   output logic                AUD_ADCDAT,
   input  logic                AUD_DACDAT,
   output logic [WORD_W-1:0]   dac_l,
   output logic [WORD_W-1:0]   dac_r,
   output logic                dac_valid,
   output logic                underrun
);

   localparam int PW    = 2 * WORD_W;
   localparam int CNT_W = $clog2(HALF_LEN);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_LEN - 1);
   localparam logic [CNT_W:0]   WIN_LO   = (CNT_W + 1)'(DELAY);
   localparam logic [CNT_W:0]   WIN_HI   = (CNT_W + 1)'(DELAY + WORD_W);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               lrck_q, lrck_d;
   logic               start_left;
   logic               frame_end;
   logic               in_win;

   logic [PW-1:0]      tx_q;
   logic [PW-1:0]      rx_q, rx_d;

   logic [PW-1:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;
   logic               full, empty, push, pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign s_ready = !full;
   assign push    = s_valid && !full;
   // An empty FIFO at frame start underruns; a same-edge push still lands in the FIFO.
   assign pop     = start_left && !empty;

   assign in_win = (state_q == RUN) && ({1'b0, cnt_q} >= WIN_LO) && ({1'b0, cnt_q} < WIN_HI);

   assign AUD_ADCLRCK = lrck_q;
   assign AUD_DACLRCK = lrck_q;
   assign AUD_ADCDAT  = in_win & tx_q[PW-1];

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lrck_d     = lrck_q;
      start_left = 1'b0;
      frame_end  = 1'b0;
      rx_d       = in_win ? {rx_q[PW-2:0], AUD_DACDAT} : rx_q;
      unique case (state_q)
         IDLE: begin
            lrck_d = 1'b1;
            cnt_d  = '0;
            if (en) begin
               state_d    = RUN;
               lrck_d     = 1'b0;
               start_left = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (lrck_q) begin
                  frame_end = 1'b1;
                  if (en) begin
                     lrck_d     = 1'b0;
                     start_left = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  lrck_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge AUD_BCLK) begin
      if (!NRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lrck_q    <= 1'b1;
         tx_q      <= '0;
         rx_q      <= '0;
         dac_l     <= '0;
         dac_r     <= '0;
         dac_valid <= 1'b0;
         underrun  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lrck_q    <= lrck_d;
         rx_q      <= rx_d;
         dac_valid <= frame_end;
         // rx_d includes this edge's bit when the window ends on the last cycle.
         if (frame_end) begin
            dac_l <= rx_d[PW-1:WORD_W];
            dac_r <= rx_d[WORD_W-1:0];
         end
         if (start_left) begin
            tx_q <= empty ? '0 : mem[rd_ptr];
         end else if (in_win) begin
            tx_q <= {tx_q[PW-2:0], 1'b0};
         end
         if (start_left && empty) underrun <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; the reset pointers and occupancy make stale
   // entries unreachable, and leaving it out lets the array map to plain RAM.
   always_ff @(posedge AUD_BCLK) begin
      if (NRST && push) mem[wr_ptr] <= s_data;
   end

endmodule

// File: tb/tb_aud_codec_emu.sv
// Self-checking bench for aud_codec_emu: frame-position reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_aud_codec_emu;

   localparam int W     = 16;
   localparam int HL    = 32;
   localparam int DL    = 1;
   localparam int DEPTH = 4;

   logic          bclk = 1'b0;
   logic          nrst = 1'b0;
   logic          en = 1'b0;
   logic          s_valid = 1'b0;
   logic [2*W-1:0] s_data = '0;
   logic          loop = 1'b0;
   logic          dac_rand = 1'b0;
   logic          chk_en = 1'b0;

   logic          s_ready, adclrck, daclrck, adcdat, dacdat, dac_valid, underrun;
   logic [W-1:0]  dac_l, dac_r;

   int checks = 0;
   int errors = 0;

   assign dacdat = loop ? adcdat : dac_rand;

   aud_codec_emu #(.WORD_W(W), .HALF_LEN(HL), .DELAY(DL), .FIFO_DEPTH(DEPTH)) dut (
      .AUD_BCLK(bclk), .NRST(nrst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .AUD_ADCLRCK(adclrck), .AUD_DACLRCK(daclrck), .AUD_ADCDAT(adcdat),
      .AUD_DACDAT(dacdat), .dac_l(dac_l), .dac_r(dac_r), .dac_valid(dac_valid),
      .underrun(underrun)
   );

   always #5 bclk = ~bclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position 0..2*HL-1 from the start of the left half.
   logic [2*W-1:0] q[$];
   logic           m_run = 1'b0;
   int             m_pos = 0;
   logic [2*W-1:0] m_cur = '0;
   logic           m_und = 1'b0;
   logic           m_valid = 1'b0;
   logic [W-1:0]   m_dl = '0, m_dr = '0, cap_l = '0, cap_r = '0;

   function automatic logic m_lrck_now();
      if (!m_run) return 1'b1;
      return (m_pos >= HL);
   endfunction

   function automatic logic m_adc_now();
      int k;
      if (!m_run) return 1'b0;
      k = (m_pos % HL) - DL;
      if (k < 0 || k >= W) return 1'b0;
      return (m_pos < HL) ? m_cur[2*W-1-k] : m_cur[W-1-k];
   endfunction

   always @(posedge bclk) begin : model_step
      logic din;
      logic do_push, start;
      int   k;
      din = loop ? m_adc_now() : dac_rand;
      if (!nrst) begin
         q.delete();
         m_run = 1'b0; m_pos = 0; m_cur = '0; m_und = 1'b0; m_valid = 1'b0;
         m_dl = '0; m_dr = '0; cap_l = '0; cap_r = '0;
      end else begin
         m_valid = 1'b0;
         do_push = s_valid && (q.size() < DEPTH);
         start = 1'b0;
         if (m_run) begin
            k = (m_pos % HL) - DL;
            if (k >= 0 && k < W) begin
               if (m_pos < HL) cap_l[W-1-k] = din;
               else            cap_r[W-1-k] = din;
            end
            if (m_pos == 2*HL-1) begin
               m_dl = cap_l; m_dr = cap_r; m_valid = 1'b1;
               if (en) start = 1'b1;
               else    m_run = 1'b0;
            end else begin
               m_pos++;
            end
         end else if (en) begin
            start = 1'b1;
         end
         if (start) begin
            m_run = 1'b1;
            m_pos = 0;
            if (q.size() > 0) m_cur = q.pop_front();
            else begin
               m_cur = '0;
               m_und = 1'b1;
            end
         end
         if (do_push) q.push_back(s_data);
      end
   end

   always @(negedge bclk) begin
      if (chk_en)
         check("outputs",
               64'({adclrck, daclrck, adcdat, s_ready, dac_valid, underrun, dac_l, dac_r}),
               64'({m_lrck_now(), m_lrck_now(), m_adc_now(), 1'(q.size() < DEPTH),
                    m_valid, m_und, m_dl, m_dr}));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge bclk);
         #2;
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      en = 1'b0;
      s_valid = 1'b0;
      step(2);
      nrst = 1'b1;
   endtask

   task automatic push(input logic [2*W-1:0] d);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_data = d;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge bclk);
         done = s_ready;
         @(posedge bclk);
         #2;
      end
      s_valid = 1'b0;
      if (!done) check("push_timeout", 64'(0), 64'(1));
   endtask

   task automatic wait_pos(input int target);
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge bclk);
         found = m_run && (m_pos == target);
      end
      if (!found) check("wait_pos_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      logic [63:0] vec, mvec;
      int          cnt;
      bit          seen;

      do_reset();
      chk_en = 1'b1;
      @(negedge bclk);
      check("reset_state", 64'({adclrck, adcdat, s_ready, underrun, dac_valid}), 64'(5'b10100));

      // Left-justified-after-one-bit I2S frame of a known pair.
      step(1);
      push({16'hA5C3, 16'h0F0F});
      en = 1'b1;
      @(posedge bclk);
      vec = '0;
      mvec = '0;
      for (int i = 0; i < 64; i++) begin
         @(negedge bclk);
         if (i == 0) check("lrck_falls", 64'(adclrck), 64'(0));
         vec  = {vec[62:0], adcdat};
         mvec = {mvec[62:0], m_adc_now()};
      end
      en = 1'b0;
      check("adc_seq", vec, 64'h52E18000_07878000);
      check("model_adc_seq", mvec, 64'h52E18000_07878000);
      check("no_underrun", 64'(underrun), 64'(0));
      step(5);

      // Loopback capture.
      loop = 1'b1;
      push({16'h8001, 16'h7FFE});
      en = 1'b1;
      step(1);
      en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge bclk);
         seen = dac_valid;
      end
      check("dac_valid_seen", 64'(seen), 64'(1));
      check("dac_pair", 64'({dac_l, dac_r}), 64'h8001_7FFE);
      check("model_dac_pair", 64'({m_dl, m_dr}), 64'h8001_7FFE);
      step(3);
      loop = 1'b0;

      // FIFO full backpressure and in-order drain.
      for (int i = 0; i < 4; i++) push(32'h1111_0000 * (i + 1) + 32'(i));
      s_valid = 1'b1;
      s_data = 32'h5555_AAAA;
      @(negedge bclk);
      check("ready_low_full", 64'(s_ready), 64'(0));
      check("model_occupancy", 64'(q.size()), 64'(4));
      en = 1'b1;
      @(posedge bclk);
      #2;
      @(negedge bclk);
      check("ready_after_pop", 64'(s_ready), 64'(1));
      @(posedge bclk);
      #2;
      s_valid = 1'b0;
      step(6 * 2 * HL);
      en = 1'b0;
      step(2 * HL + 4);

      // Underrun is sticky across later pushes.
      do_reset();
      en = 1'b1;
      step(1);
      @(negedge bclk);
      check("underrun_set", 64'(underrun), 64'(1));
      push(32'hDEAD_BEEF);
      step(10);
      check("underrun_sticky", 64'(underrun), 64'(1));
      check("model_underrun", 64'(m_und), 64'(1));
      en = 1'b0;
      step(3 * HL + 4);

      // en dropped mid-left-half finishes the frame.
      do_reset();
      push(32'h1234_5678);
      en = 1'b1;
      wait_pos(5);
      en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge bclk);
         if (!adclrck) cnt++;
      end
      check("left_half_rest", 64'(cnt), 64'(26));
      check("idle_lrck", 64'(adclrck), 64'(1));
      check("model_idle", 64'(m_run), 64'(0));

      // Reset in the middle of a right half.
      push(32'hCAFE_F00D);
      push(32'hBEEF_0001);
      en = 1'b1;
      wait_pos(HL + 10);
      nrst = 1'b0;
      en = 1'b0;
      @(posedge bclk);
      #2;
      nrst = 1'b1;
      @(negedge bclk);
      check("rst_mid", 64'({adclrck, adcdat, s_ready}), 64'(3'b101));
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge bclk);
         if (dac_valid) cnt++;
      end
      check("no_partial_dac", 64'(cnt), 64'(0));

      // Randomized traffic with occasional en toggles and resets.
      en = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(posedge bclk);
         #2;
         s_valid  = ($urandom_range(0, 99) < 8);
         s_data   = $urandom();
         dac_rand = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) en = ~en;
         if (i % 700 == 0) loop = 1'($urandom_range(0, 1));
         nrst = ($urandom_range(0, 1499) != 0);
      end
      nrst = 1'b1;
      step(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aud_codec_emu.md
AUD_CODEC_EMU -- requirements
Module: aud_codec_emu

Purpose: codec-side end of the audio serial link. Acts as the LRCK master and ADC-data transmitter toward the FPGA-side deserializer, and captures the FPGA's DAC serial stream. Used for loopback and bench stimulus in place of the board codec.

Interface
REQ-001 Parameter WORD_W, default 16: bits per channel word.
REQ-002 Parameter HALF_LEN, default 32: AUD_BCLK cycles per LRCK half-period; legal range WORD_W+DELAY to 256.
REQ-003 Parameter DELAY, default 1: BCLK cycles from start of half to MSB; 0 selects left-justified, 1 selects I2S.
REQ-004 Parameter FIFO_DEPTH, default 4: stereo sample pairs buffered; must be a power of 2.
REQ-005 AUD_BCLK  in  1  bit clock; all logic on its rising edge.
REQ-006 NRST  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  frame generation enable.
REQ-008 s_valid  in  1  input pair valid.
REQ-009 s_ready  out  1  FIFO can accept a pair.
REQ-010 s_data  in  2*WORD_W  {left, right} pair to transmit.
REQ-011 AUD_ADCLRCK  out  1  ADC LR clock; 0 = left, 1 = right.
REQ-012 AUD_DACLRCK  out  1  DAC LR clock; always equal to AUD_ADCLRCK.
REQ-013 AUD_ADCDAT  out  1  serial ADC data, MSB first.
REQ-014 AUD_DACDAT  in  1  serial DAC data from the FPGA-side transmitter.
REQ-015 dac_l, dac_r  out  WORD_W each  last captured DAC pair.
REQ-016 dac_valid  out  1  one-cycle strobe: new dac_l/dac_r.
REQ-017 underrun  out  1  sticky flag: a frame started with the FIFO empty.

Function
REQ-018 The block SHALL use two states: IDLE and RUN.
REQ-019 In IDLE it SHALL hold LRCK=1, ADCDAT=0 and cnt=0.
REQ-020 The IDLE->RUN transition SHALL occur when en=1 at a clock edge; on the following cycle LRCK=0 and cnt=0, which starts the left half.
REQ-021 In RUN, cnt SHALL count 0..HALF_LEN-1; on wrap to 0, LRCK SHALL toggle on the same edge.
REQ-022 If en=0 in RUN, the block SHALL finish the current frame; on the edge that would begin the next left half, it SHALL enter IDLE instead.
REQ-023 On each entry to a left half, the block SHALL pop the FIFO head into the 2*WORD_W tx shift register.
REQ-024 If the FIFO is empty at entry to a left half, the block SHALL load zeros and set underrun.
REQ-025 While cnt = k+DELAY (k = 0..WORD_W-1), ADCDAT SHALL carry bit WORD_W-1-k of the current channel's word; at all other cnt values ADCDAT SHALL be 0.
REQ-026 While cnt = k+DELAY, the block SHALL register AUD_DACDAT as bit WORD_W-1-k of the DAC shift register for the current channel.
REQ-027 On the last cycle of each right half (cnt=HALF_LEN-1, LRCK=1), the block SHALL load the captured left and right words into dac_l and dac_r on that edge and pulse dac_valid high for exactly 1 cycle.
REQ-028 s_ready SHALL equal !full.
REQ-029 A push SHALL occur when s_valid && s_ready; when ready is low, s_data SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL both take effect: occupancy unchanged if the FIFO was non-empty; if it was empty, the pop underruns and the pushed pair is stored.
REQ-031 A push refused while full SHALL be retried only by the source; no data is dropped internally.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-033 underrun SHALL clear only on reset.

Reset
REQ-034 NRST=0 at any edge, including mid-frame, SHALL force: state IDLE; cnt=0; AUD_ADCLRCK=AUD_DACLRCK=1; AUD_ADCDAT=0; FIFO empty; s_ready=1; dac_l=dac_r=0; dac_valid=0; underrun=0; all shift registers 0.
REQ-035 Reset SHALL take priority over push, pop and en.

Verification
REQ-036 With defaults, push {16'hA5C3, 16'h0F0F}, then en=1: LRCK falls; ADCDAT emits A5C3 MSB first on cnt 1..16 and 0 on cnt 17..31; LRCK rises; ADCDAT emits 0F0F; underrun=0.
REQ-037 With en=1 and no push: the first frame transmits all zeros; underrun=1 and stays 1 after a later push.
REQ-038 Push 5 pairs with en=0: s_ready drops after the 4th push and the 5th is held; after the first frame starts, s_ready=1 and the 5th pair is accepted; the frames transmit the 5 pairs in push order.
REQ-039 Loop AUD_ADCDAT to AUD_DACDAT, push {16'h8001, 16'h7FFE}: at the end of the frame, dac_valid pulses once with dac_l=8001, dac_r=7FFE.
REQ-040 Assert NRST=0 at cnt=10 of a right half: next cycle LRCK=1, ADCDAT=0, FIFO empty, dac_valid never pulses for the partial frame.
REQ-041 Drop en at cnt=5 of a left half: the frame completes (64 cycles from its start); the block then holds IDLE with LRCK=1.
